// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types for the AXI-Lite read slave
// Purpose: response codes and read-slave FSM state encoding.
// Ports: none (package).
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rd_slave_state_t;

endpackage

// File: rtl/axil_rd_slave_if.sv
// rtl/axil_rd_slave_if.sv - AXI-Lite read address / read data channel bundle
// Purpose: groups the AR and R channel signals of one AXI-Lite read port.
// Ports: ARADDR, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY;
//        modport slave (responder side), modport master (requester side).
interface axil_rd_slave_if
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  resp_t                 RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - register array with local write port and indexed read
// Purpose: holds NUM_REGS data registers, written locally, read combinationally.
// Ports: clk, rst (async active-low); wr_en/wr_idx/wr_data write port;
//        rd_idx in, rd_data out (combinational read of the current contents).
module axil_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Read sees the pre-write value when a write to the same index lands this edge.
  assign rd_data = regs_q[rd_idx];
endmodule

// File: rtl/axil_rd_slave.sv
// rtl/axil_rd_slave.sv - AXI-Lite read-only register slave, one outstanding read
// Purpose: decodes AR addresses onto a local register bank and returns R responses.
// Ports: clk, rst (async active-low); bus (axil_rd_slave_if.slave, AR/R channels);
//        wr_en/wr_idx/wr_data local register write port.
// Config: define AXIL_RD_LATENCY_EN to add a WAIT state of RD_LATENCY cycles.
module axil_rd_slave
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RD_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  axil_rd_slave_if.slave              bus,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]       wr_data
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(NUM_REGS * 4);

  if (RD_LATENCY < 1 || RD_LATENCY > 15 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_param_check
    $error("axil_rd_slave: RD_LATENCY must be 1..15 and NUM_REGS a power of two");
  end

  rd_slave_state_t       state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  resp_t                 dec_resp;
  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] dec_addr, dec_off;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  axil_reg_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign ar_hs = (state_q == IDLE) && arready_q && bus.ARVALID;

`ifdef AXIL_RD_LATENCY_EN
  localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [3:0]            cnt_q, cnt_d;

  // Response is formed when leaving WAIT, so decode the captured address.
  assign dec_addr = araddr_q;

  always_comb begin
    araddr_d = araddr_q;
    cnt_d    = cnt_q;
    if (ar_hs) begin
      araddr_d = bus.ARADDR;
      cnt_d    = LAT_M1;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      araddr_q <= '0;
      cnt_q    <= 4'd0;
    end else begin
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  // Response is formed on the handshake edge itself, straight from ARADDR.
  assign dec_addr = bus.ARADDR;
`endif

  // Unsigned subtraction: addresses below BASE_ADDR wrap high and land in DECERR.
  assign dec_off = dec_addr - BASE_ADDR;
  assign rd_idx  = dec_off[IDX_W+1:2];

  always_comb begin
    dec_resp = OKAY;
    if (dec_addr[1:0] != 2'b00) begin
      dec_resp = SLVERR;
    end else if (dec_off >= REGION_BYTES) begin
      dec_resp = DECERR;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
`ifdef AXIL_RD_LATENCY_EN
          state_d = WAIT;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef AXIL_RD_LATENCY_EN
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
      end
`endif
      RESP: begin
        if (rvalid_q && bus.RREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    arready_d = (state_d == IDLE);
    rvalid_d  = (state_d == RESP);

    // Capture the response only on entry to RESP so it holds until accepted.
    if (state_q != RESP && state_d == RESP) begin
      rresp_d = dec_resp;
      rdata_d = (dec_resp == OKAY) ? rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
endmodule

// File: tb/tb_axil_rd_slave.sv
// tb/tb_axil_rd_slave.sv - directed self-checking bench for axil_rd_slave
module tb_axil_rd_slave;
`ifdef AXIL_RD_LATENCY_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  int          checks;
  int          failures;

  axil_rd_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_rd_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (16),
    .BASE_ADDR  (32'h0000_0000),
    .RD_LATENCY (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    string       nm;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic local_wr(input logic [3:0] idx, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_rvalid(output int cyc);
    cyc = 1;
    while (!bus.RVALID && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input string nm);
    int cyc;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b0;
    cyc = 0;
    while (!bus.ARREADY && cyc < 20) begin
      step();
      cyc++;
    end
    chk({31'd0, bus.ARREADY}, 32'd1, {nm, ".arready_pre"});
    step();
    bus.ARVALID = 1'b0;
    wait_rvalid(cyc);
    chk(32'(cyc), 32'(EXP_LAT), {nm, ".latency"});
    chk(bus.RDATA, exp_d, {nm, ".rdata"});
    chk({30'd0, bus.RRESP}, {30'd0, exp_r}, {nm, ".rresp"});
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    chk({31'd0, bus.RVALID}, 32'd0, {nm, ".rvalid_drop"});
    chk({31'd0, bus.ARREADY}, 32'd1, {nm, ".arready_back"});
  endtask

  initial begin
    int cyc;
    int seen;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
    bus.ARADDR  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;

    vecs[0] = '{32'h0000_000C, 32'hDEAD_BEEF, 2'b00, "rd_reg3"};
    vecs[1] = '{32'h0000_0006, 32'h0000_0000, 2'b10, "rd_misaligned06"};
    vecs[2] = '{32'h0000_0040, 32'h0000_0000, 2'b11, "rd_outside40"};
    vecs[3] = '{32'h0000_003C, 32'hF0F0_F0F0, 2'b00, "rd_reg15"};
    vecs[4] = '{32'h0000_0000, 32'hA0A0_A0A0, 2'b00, "rd_reg0"};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b11, "rd_wrap_high"};
    vecs[6] = '{32'h0000_003E, 32'h0000_0000, 2'b10, "rd_misaligned3E"};
    vecs[7] = '{32'h0000_0041, 32'h0000_0000, 2'b10, "rd_misaligned41"};

    // Reset state
    #1 rst = 1'b0;
    repeat (3) step();
    chk({31'd0, bus.ARREADY}, 32'd0, "reset.arready");
    chk({31'd0, bus.RVALID}, 32'd0, "reset.rvalid");
    chk(bus.RDATA, 32'd0, "reset.rdata");
    chk({30'd0, bus.RRESP}, 32'd0, "reset.rresp");
    rst = 1'b1;
    #1;
    chk({31'd0, bus.ARREADY}, 32'd0, "reset.arready_before_edge");
    step();
    chk({31'd0, bus.ARREADY}, 32'd1, "reset.arready_first_edge");

    local_wr(4'd3, 32'hDEAD_BEEF);
    local_wr(4'd0, 32'hA0A0_A0A0);
    local_wr(4'd15, 32'hF0F0_F0F0);

    for (int i = 0; i < 8; i++) begin
      do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].nm);
    end

    // Hold RREADY low for 5 cycles with a competing ARVALID pending
    bus.ARADDR  = 32'h0000_000C;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b0;
    step();
    bus.ARADDR = 32'h0000_0040;
    wait_rvalid(cyc);
    chk(32'(cyc), 32'(EXP_LAT), "hold.latency");
    for (int k = 0; k < 5; k++) begin
      chk({31'd0, bus.RVALID}, 32'd1, "hold.rvalid");
      chk(bus.RDATA, 32'hDEAD_BEEF, "hold.rdata");
      chk({30'd0, bus.RRESP}, 32'd0, "hold.rresp");
      chk({31'd0, bus.ARREADY}, 32'd0, "hold.arready");
      step();
    end
    bus.RREADY = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    chk({31'd0, bus.RVALID}, 32'd0, "hold.rvalid_drop");
    chk({31'd0, bus.ARREADY}, 32'd1, "hold.arready_back");
    seen = 0;
    for (int k = 0; k < EXP_LAT + 2; k++) begin
      step();
      if (bus.RVALID || !bus.ARREADY) seen = 1;
    end
    chk(32'(seen), 32'd0, "hold.pending_ar_ignored");

    // Local write to the same register on the RDATA-load edge
    bus.ARADDR  = 32'h0000_0004;
    bus.ARVALID = 1'b1;
    for (int k = 0; k < EXP_LAT; k++) begin
      if (k == EXP_LAT - 1) begin
        wr_en   = 1'b1;
        wr_idx  = 4'd1;
        wr_data = 32'h0000_1111;
      end
      step();
      if (k == 0) bus.ARVALID = 1'b0;
    end
    wr_en = 1'b0;
    chk({31'd0, bus.RVALID}, 32'd1, "collide.rvalid");
    chk(bus.RDATA, 32'h0000_0000, "collide.rdata_prewrite");
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    do_read(32'h0000_0004, 32'h0000_1111, 2'b00, "collide.reread");

    // Back-to-back reads reg0 then reg15 with RREADY tied high
    bus.RREADY  = 1'b1;
    bus.ARADDR  = 32'h0000_0000;
    bus.ARVALID = 1'b1;
    chk({31'd0, bus.ARREADY}, 32'd1, "b2b.arready0");
    step();
    bus.ARADDR = 32'h0000_003C;
    wait_rvalid(cyc);
    chk(32'(cyc), 32'(EXP_LAT), "b2b.latency0");
    chk(bus.RDATA, 32'hA0A0_A0A0, "b2b.rdata0");
    step();
    chk({31'd0, bus.RVALID}, 32'd0, "b2b.rvalid_drop0");
    chk({31'd0, bus.ARREADY}, 32'd1, "b2b.arready_back0");
    step();
    bus.ARVALID = 1'b0;
    wait_rvalid(cyc);
    chk(32'(cyc), 32'(EXP_LAT), "b2b.latency1");
    chk(bus.RDATA, 32'hF0F0_F0F0, "b2b.rdata1");
    step();
    chk({31'd0, bus.RVALID}, 32'd0, "b2b.rvalid_drop1");
    chk({31'd0, bus.ARREADY}, 32'd1, "b2b.arready_back1");
    bus.RREADY = 1'b0;

    // Reset in the middle of a read
    bus.ARADDR  = 32'h0000_000C;
    bus.ARVALID = 1'b1;
    if (EXP_LAT > 1) begin
      step();
      bus.ARVALID = 1'b0;
      rst = 1'b0;
    end else begin
      rst = 1'b0;
      step();
      bus.ARVALID = 1'b0;
    end
    #1;
    chk({31'd0, bus.RVALID}, 32'd0, "midrst.rvalid_in_reset");
    chk({31'd0, bus.ARREADY}, 32'd0, "midrst.arready_in_reset");
    step();
    step();
    rst = 1'b1;
    #1;
    chk({31'd0, bus.ARREADY}, 32'd0, "midrst.arready_before_edge");
    step();
    chk({31'd0, bus.ARREADY}, 32'd1, "midrst.arready_after_release");
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.RVALID) seen = 1;
      step();
    end
    chk(32'(seen), 32'd0, "midrst.no_response");
    do_read(32'h0000_000C, 32'h0000_0000, 2'b00, "midrst.next_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
